// File: rtl/usb_rx_nrzi_decoder.sv
// usb_rx_nrzi_decoder: USB receive path with SYNC detect, NRZI decode, bit unstuffing and EOP/error handling
module usb_rx_nrzi_decoder #(
  parameter int SYNC_MIN    = 5,
  parameter int IDLE_J_BITS = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] usb_line_state,
  input  logic       bit_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_error
);
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;
  localparam int JW = $clog2(IDLE_J_BITS + 1);
  localparam logic [2:0]    SYNC_MIN_C = 3'(SYNC_MIN);
  localparam logic [JW-1:0] IDLE_J_C   = JW'(IDLE_J_BITS);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERROR} state_t;
  state_t        state_q, state_d;
  logic [1:0]    prev_q, prev_d;
  logic [2:0]    alt_cnt_q, alt_cnt_d;
  logic [2:0]    ones_cnt_q, ones_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    se0_cnt_q, se0_cnt_d;
  logic [JW-1:0] j_cnt_q, j_cnt_d;
  logic          se0_seen_q, se0_seen_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_active_q, rx_active_d;
  logic          rx_eop_q, rx_eop_d;
  logic          rx_error_q, rx_error_d;
  logic          is_jk, nrzi_bit, err;
  // Next-state logic: decode one line code per bit_en strobe; any error funnels through err
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    alt_cnt_d   = alt_cnt_q;
    ones_cnt_d  = ones_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    se0_cnt_d   = se0_cnt_q;
    j_cnt_d     = j_cnt_q;
    se0_seen_d  = se0_seen_q;
    sr_d        = sr_q;
    rx_data_d   = rx_data_q;
    rx_active_d = rx_active_q;
    rx_valid_d  = 1'b0;
    rx_eop_d    = 1'b0;
    rx_error_d  = 1'b0;
    err         = 1'b0;
    is_jk       = usb_line_state == LS_J || usb_line_state == LS_K;
    nrzi_bit    = usb_line_state == prev_q;
    if (bit_en) begin
      if (is_jk) prev_d = usb_line_state;
      case (state_q)
        IDLE:
          if (usb_line_state == LS_K && prev_q == LS_J) begin
            state_d   = SYNC;
            alt_cnt_d = '0;
          end
        SYNC:
          if (is_jk && !nrzi_bit) alt_cnt_d = alt_cnt_q == 3'd7 ? 3'd7 : alt_cnt_q + 3'd1;
          else if (usb_line_state == LS_K && alt_cnt_q >= SYNC_MIN_C) begin
            state_d     = DATA;
            rx_active_d = 1'b1;
            ones_cnt_d  = 3'd1;
            bit_cnt_d   = '0;
          end
          else state_d = IDLE;
        DATA:
          if (usb_line_state == LS_SE0) begin
            state_d   = EOP;
            se0_cnt_d = 2'd1;
          end
          else if (usb_line_state == LS_SE1) err = 1'b1;
          else if (ones_cnt_q == 3'd6) begin
            err        = nrzi_bit;
            ones_cnt_d = '0;
          end
          else begin
            sr_d       = {nrzi_bit, sr_q[7:1]};
            ones_cnt_d = nrzi_bit ? ones_cnt_q + 3'd1 : '0;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = sr_d;
              rx_valid_d = 1'b1;
            end
          end
        EOP:
          if (usb_line_state == LS_SE0) begin
            se0_cnt_d = se0_cnt_q + 2'd1;
            err       = se0_cnt_q == 2'd2;
          end
          else if (usb_line_state == LS_J) begin
            state_d     = IDLE;
            rx_eop_d    = 1'b1;
            rx_active_d = 1'b0;
            rx_error_d  = bit_cnt_q != 3'd0;
          end
          else err = 1'b1;
        ERROR:
          if (usb_line_state == LS_SE0) begin
            se0_seen_d = 1'b1;
            j_cnt_d    = '0;
          end
          else if (usb_line_state == LS_J) begin
            j_cnt_d = j_cnt_q + JW'(1);
            if (se0_seen_q || j_cnt_d == IDLE_J_C) state_d = IDLE;
          end
          else begin
            se0_seen_d = 1'b0;
            j_cnt_d    = '0;
          end
        default: state_d = IDLE;
      endcase
      if (err) begin
        state_d     = ERROR;
        rx_error_d  = 1'b1;
        rx_active_d = 1'b0;
        se0_seen_d  = 1'b0;
        j_cnt_d     = '0;
      end
    end
  end
  // State and output registers; reset drops any packet in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= LS_J;
      alt_cnt_q   <= '0;
      ones_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      se0_cnt_q   <= '0;
      j_cnt_q     <= '0;
      se0_seen_q  <= 1'b0;
      sr_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_active_q <= 1'b0;
      rx_eop_q    <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      alt_cnt_q   <= alt_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      se0_cnt_q   <= se0_cnt_d;
      j_cnt_q     <= j_cnt_d;
      se0_seen_q  <= se0_seen_d;
      sr_q        <= sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_active_q <= rx_active_d;
      rx_eop_q    <= rx_eop_d;
      rx_error_q  <= rx_error_d;
    end
  end
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_active = rx_active_q;
  assign rx_eop    = rx_eop_q;
  assign rx_error  = rx_error_q;
endmodule

// File: tb/tb_usb_rx_nrzi_decoder.sv
// tb_usb_rx_nrzi_decoder: packet-level encoder model driving the decoder with randomized bit_en spacing
module tb_usb_rx_nrzi_decoder;
  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] J   = 2'b01;
  localparam logic [1:0] K   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_en = 1'b0;
  logic [1:0] line = J;
  logic [7:0] rx_data;
  logic rx_valid, rx_active, rx_eop, rx_error;
  int checks = 0, errors = 0;
  int val_n = 0, eop_n = 0, err_n = 0;
  int exp_val = 0, exp_eop = 0, exp_err = 0;
  string phase = "init";
  logic [1:0] cq[$];
  int vq[$];
  logic [7:0] bq[$];
  logic [1:0] enc_p;
  int enc_ones;
  usb_rx_nrzi_decoder dut (
    .clk(clk), .rst_n(rst_n), .usb_line_state(line), .bit_en(bit_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active),
    .rx_eop(rx_eop), .rx_error(rx_error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n) begin
    if (rx_valid) val_n++;
    if (rx_eop) eop_n++;
    if (rx_error) err_n++;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask
  task automatic send(input logic [1:0] c);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      bit_en = 1'b0;
      line = 2'($urandom);
    end
    @(negedge clk);
    bit_en = 1'b1;
    line = c;
    @(negedge clk);
    bit_en = 1'b0;
    line = 2'($urandom);
  endtask
  // markers: >=0 byte completes, -1 quiet, -2 active now, -3 good EOP, -4 EOP with error, -5 error entry, -6 inactive
  task automatic push(input logic [1:0] c, input int v);
    cq.push_back(c);
    vq.push_back(v);
  endtask
  task automatic enc_start(input int npre);
    repeat (npre) push(J, -1);
    for (int i = 0; i < 7; i++) push(i % 2 ? J : K, -1);
    push(K, -2);
    enc_p = K;
    enc_ones = 1;
  endtask
  task automatic enc_raw(input logic b, input int v);
    if (!b) enc_p ^= 2'b11;
    push(enc_p, v);
  endtask
  task automatic enc_byte(input logic [7:0] b);
    for (int k = 0; k < 8; k++) begin
      if (enc_ones == 6) begin
        enc_raw(1'b0, -1);
        enc_ones = 0;
      end
      enc_raw(b[k], k == 7 ? int'(b) : -1);
      enc_ones = b[k] ? enc_ones + 1 : 0;
    end
  endtask
  task automatic play();
    logic ev, ee, er;
    foreach (cq[i]) begin
      send(cq[i]);
      ev = vq[i] >= 0;
      ee = vq[i] == -3 || vq[i] == -4;
      er = vq[i] == -4 || vq[i] == -5;
      check("rx_valid", 32'(rx_valid), 32'(ev));
      check("rx_eop", 32'(rx_eop), 32'(ee));
      check("rx_error", 32'(rx_error), 32'(er));
      if (ev) check("rx_data", 32'(rx_data), 32'(vq[i]));
      if (vq[i] == -2) check("rx_active_on", 32'(rx_active), 32'd1);
      if (vq[i] <= -3) check("rx_active_off", 32'(rx_active), 32'd0);
      if (ev) exp_val++;
      if (ee) exp_eop++;
      if (er) exp_err++;
    end
    cq.delete();
    vq.delete();
  endtask
  task automatic packet(input int npre);
    enc_start(npre);
    foreach (bq[i]) enc_byte(bq[i]);
    if (enc_ones == 6) enc_raw(1'b0, -1);
    push(SE0, -1);
    push(SE0, -1);
    push(J, -3);
    play();
    check("rx_data_hold", 32'(rx_data), 32'(bq[bq.size() - 1]));
  endtask
  task automatic pk1(input logic [7:0] b, input int npre);
    bq.delete();
    bq.push_back(b);
    packet(npre);
  endtask
  initial begin
    phase = "reset";
    repeat (3) @(negedge clk);
    check("rx_data", 32'(rx_data), 32'd0);
    check("rx_valid", 32'(rx_valid), 32'd0);
    check("rx_active", 32'(rx_active), 32'd0);
    check("rx_eop", 32'(rx_eop), 32'd0);
    check("rx_error", 32'(rx_error), 32'd0);
    rst_n = 1'b1;
    phase = "a5";
    pk1(8'hA5, 3);
    phase = "ff_stuff";
    pk1(8'hFF, 2);
    phase = "stuff_boundary";
    bq.delete();
    bq.push_back(8'hFC);
    bq.push_back(8'h01);
    bq.push_back(8'hFF);
    packet(2);
    phase = "stuff_err";
    enc_start(2);
    for (int i = 0; i < 7; i++) enc_raw(1'b1, i == 5 ? -5 : -1);
    for (int i = 0; i < 7; i++) push(J, -1);
    play();
    pk1(8'h5A, 0);
    phase = "stuff_prio";
    enc_start(2);
    enc_raw(1'b0, -1);
    for (int i = 0; i < 6; i++) enc_raw(1'b1, -1);
    enc_raw(1'b1, -5);
    push(SE0, -1);
    push(J, -1);
    play();
    pk1(8'h81, 0);
    phase = "short_eop";
    enc_start(2);
    enc_raw(1'b1, -1);
    enc_raw(1'b0, -1);
    enc_raw(1'b1, -1);
    enc_raw(1'b1, -1);
    push(SE0, -1);
    push(SE0, -1);
    push(J, -4);
    play();
    pk1(8'h0F, 2);
    phase = "short_sync";
    push(J, -6);
    push(J, -6);
    push(K, -6);
    push(J, -6);
    push(K, -6);
    push(K, -6);
    play();
    pk1(8'h66, 1);
    phase = "se1_data";
    enc_start(1);
    enc_byte(8'h12);
    push(SE1, -5);
    push(SE0, -1);
    push(J, -1);
    play();
    pk1(8'h34, 0);
    phase = "long_se0";
    enc_start(1);
    enc_byte(8'h9C);
    push(SE0, -1);
    push(SE0, -1);
    push(SE0, -5);
    push(SE0, -1);
    push(J, -1);
    play();
    pk1(8'hC3, 0);
    phase = "reset_mid";
    enc_start(2);
    enc_raw(1'b1, -1);
    enc_raw(1'b0, -1);
    enc_raw(1'b1, -1);
    play();
    #3 rst_n = 1'b0;
    #1;
    check("rx_data", 32'(rx_data), 32'd0);
    check("rx_valid", 32'(rx_valid), 32'd0);
    check("rx_active", 32'(rx_active), 32'd0);
    check("rx_eop", 32'(rx_eop), 32'd0);
    check("rx_error", 32'(rx_error), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pk1(8'h3C, 2);
    phase = "random";
    for (int n = 0; n < 15; n++) begin
      bq.delete();
      repeat ($urandom_range(1, 3)) bq.push_back($urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom));
      packet(int'($urandom_range(1, 3)));
    end
    phase = "totals";
    repeat (3) @(negedge clk);
    check("valid_count", 32'(val_n), 32'(exp_val));
    check("eop_count", 32'(eop_n), 32'(exp_eop));
    check("error_count", 32'(err_n), 32'(exp_err));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usb_rx_nrzi_decoder.md
USB_RX_NRZI_DECODER -- requirements
Module: usb_rx_nrzi_decoder

Interface
REQ-001 SHALL have parameter SYNC_MIN, default 5, meaning the minimum number of J/K alternations seen in SYNC before the closing K-K pair is accepted.
REQ-002 SHALL have parameter IDLE_J_BITS, default 7, meaning the number of consecutive J bit times that releases the ERROR state.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port usb_line_state, input, 2 bits: line code 00=SE0, 01=J, 10=K, 11=SE1 (illegal).
REQ-006 SHALL have port bit_en, input, 1 bit: one-cycle strobe marking the sample point of each bit time; usb_line_state is ignored when bit_en=0.
REQ-007 SHALL have port rx_data, output, 8 bits: assembled byte, LSB first on the wire.
REQ-008 SHALL have port rx_valid, output, 1 bit: one-cycle pulse, rx_data valid.
REQ-009 SHALL have port rx_active, output, 1 bit: high from SYNC accept to EOP or error.
REQ-010 SHALL have port rx_eop, output, 1 bit: one-cycle pulse on a valid EOP.
REQ-011 SHALL have port rx_error, output, 1 bit: one-cycle pulse on any receive error.

Function
REQ-012 SHALL implement FSM states IDLE, SYNC, DATA, EOP and ERROR, and SHALL advance only on cycles with bit_en=1.
REQ-013 IDLE: a K following a J SHALL move to SYNC with alt_cnt=0; all other codes SHALL remain in IDLE.
REQ-014 SYNC: a code opposite to the previous bit SHALL increment alt_cnt, saturating at 7.
REQ-015 SYNC: K after K with alt_cnt>=SYNC_MIN SHALL move to DATA and set rx_active=1 on the next clock.
REQ-016 SYNC: J after J, K-K with alt_cnt<SYNC_MIN, SE0 or SE1 SHALL return to IDLE silently.
REQ-017 DATA: the NRZI bit SHALL be 1 when the code equals the previous J/K code and 0 when it differs.
REQ-018 DATA entry SHALL initialise ones_cnt=1 (the sync K-K counts), bit_cnt=0 and prev=K.
REQ-019 DATA: a decoded 1 SHALL increment ones_cnt, and a decoded 0 SHALL clear it.
REQ-020 DATA: when ones_cnt=6, the next bit SHALL be discarded as a stuff bit if it is 0, clearing ones_cnt and leaving bit_cnt unchanged.
REQ-021 DATA: when ones_cnt=6, a next bit of 1 SHALL be a stuff error and SHALL move to ERROR.
REQ-022 DATA: each non-stuff bit SHALL shift into the MSB of the shift register, and bit_cnt SHALL increment modulo 8.
REQ-023 On the 8th bit, rx_data SHALL update and rx_valid SHALL pulse on the clock after that bit_en, giving a latency of 1 cycle.
REQ-024 rx_data SHALL hold its value between rx_valid pulses.
REQ-025 DATA: SE0 SHALL move to EOP with se0_cnt=1.
REQ-026 DATA: SE1 SHALL move to ERROR.
REQ-027 EOP: SE0 SHALL increment se0_cnt.
REQ-028 EOP: J with se0_cnt in 1..2 SHALL go to IDLE, pulse rx_eop and clear rx_active.
REQ-029 If bit_cnt is not 0 at that EOP, rx_error SHALL pulse in the same cycle as rx_eop.
REQ-030 EOP: K, SE1 or se0_cnt reaching 3 SHALL move to ERROR.
REQ-031 ERROR entry SHALL pulse rx_error once and clear rx_active on the same clock.
REQ-032 ERROR SHALL exit to IDLE after SE0 followed by J, or after IDLE_J_BITS consecutive J codes.
REQ-033 rx_valid and rx_eop SHALL never assert while in ERROR.
REQ-034 A stuff error (REQ-021) SHALL take priority over byte completion on the same bit.
REQ-035 A stuffed 0 that arrives after the 8th bit SHALL be consumed as a stuff bit and SHALL NOT start a new byte.
REQ-036 Outputs SHALL be registered, with no combinational path from usb_line_state to any output.

Reset
REQ-037 rst_n=0 SHALL asynchronously force IDLE, rx_data=8'h00, and rx_valid=rx_active=rx_eop=rx_error=0.
REQ-038 rst_n=0 SHALL asynchronously clear all counters and set prev=J.
REQ-039 Reset asserted mid-packet SHALL abort the packet with no rx_valid, rx_eop or rx_error pulse.
REQ-040 After release, the block SHALL wait for a fresh J-to-K transition before entering SYNC.

Verification
REQ-041 J idle, SYNC KJKJKJKK, byte 8'hA5 NRZI, SE0 SE0 J -> one rx_valid with rx_data=8'hA5, then rx_eop=1 with rx_error=0.
REQ-042 SYNC, byte 8'hFF with a stuffed transition after the 6th one, EOP -> rx_data=8'hFF, exactly 8 data bits counted, no rx_error.
REQ-043 SYNC, then 7 consecutive unchanged codes -> rx_error pulse, rx_active=0, no rx_valid; 7 J codes later -> back in IDLE.
REQ-044 SYNC, 4 data bits, then SE0 SE0 J -> rx_eop and rx_error pulse in the same cycle, no rx_valid.
REQ-045 SYNC KJKK (alt_cnt=2) -> no rx_active, state returns to IDLE.
REQ-046 rst_n=0 asserted mid-byte and released -> all outputs 0; the next valid packet 8'h3C decodes correctly.
